// File: rtl/risc32_dbg_pkg.sv
// Shared opcodes, response codes and FSM states for the Risc32 debug bridge.
package risc32_dbg_pkg;

    localparam logic [7:0] OP_WR_IM  = 8'h01;
    localparam logic [7:0] OP_WR_DM  = 8'h02;
    localparam logic [7:0] OP_WR_RF  = 8'h03;
    localparam logic [7:0] OP_RD_DM  = 8'h04;
    localparam logic [7:0] OP_RD_RF  = 8'h05;
    localparam logic [7:0] OP_SET_PC = 8'h06;
    localparam logic [7:0] OP_STEP   = 8'h07;
    localparam logic [7:0] OP_RUN    = 8'h08;
    localparam logic [7:0] OP_HALT   = 8'h09;

    localparam logic [7:0] RSP_ACK     = 8'hA5;
    localparam logic [7:0] RSP_UNKNOWN = 8'hEE;
    localparam logic [7:0] RSP_BUSY    = 8'hE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_EXEC,
        ST_RSP
    } dbg_state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op >= OP_WR_IM) && (op <= OP_HALT);
    endfunction

    // Opcodes 0x01-0x06 carry an address byte and need the core halted.
    function automatic logic op_has_addr(input logic [7:0] op);
        return (op >= OP_WR_IM) && (op <= OP_SET_PC);
    endfunction

    function automatic logic op_is_read(input logic [7:0] op);
        return (op == OP_RD_DM) || (op == OP_RD_RF);
    endfunction

endpackage

// File: rtl/dbg_rsp_serializer.sv
// Holds a response word and shifts it out LSB-first, one byte per valid/ready handshake.
module dbg_rsp_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [2:0]  count,
    input  logic        rsp_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_byte,
    output logic        done
);

    logic [31:0] shift_q;
    logic [2:0]  left_q;

    assign rsp_valid = (left_q != 3'd0);
    assign rsp_byte  = shift_q[7:0];
    assign done      = rsp_valid && rsp_ready && (left_q == 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= 32'h0;
            left_q  <= 3'd0;
        end else if (load) begin
            shift_q <= word;
            left_q  <= count;
        end else if (rsp_valid && rsp_ready) begin
            shift_q <= {8'h00, shift_q[31:8]};
            left_q  <= left_q - 3'd1;
        end
    end

endmodule

// File: rtl/risc32_debug_bridge.sv
// Host byte-stream to Risc32 debug ports: halt/step/run control plus IM/DM/RF/PC peek and poke.
module risc32_debug_bridge
    import risc32_dbg_pkg::*;
#(
    parameter int IM_AW = 4,
    parameter int DM_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_byte,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_byte,
    output logic              im_we,
    output logic [IM_AW-1:0]  im_addr,
    output logic [31:0]       im_wdata,
    output logic              dm_we,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_addr,
    output logic [31:0]       rf_wdata,
    input  logic [31:0]       rf_rdata,
    output logic              pc_we,
    output logic [31:0]       pc_wdata,
    output logic              cpu_halt,
    output logic              cpu_step
);

    localparam int AW_MAX = (IM_AW > DM_AW) ? IM_AW : DM_AW;
    localparam int AW     = (AW_MAX > 5) ? AW_MAX : 5;

    dbg_state_t state, state_nxt;

    logic [7:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic [1:0]    cnt_q;
    logic          halt_q;

    logic          cmd_fire;
    logic          ser_load;
    logic [31:0]   ser_word;
    logic [2:0]    ser_count;
    logic          ser_done;
    logic          exec_ok;

    assign cmd_fire = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        ser_load  = 1'b0;
        ser_word  = 32'h0;
        ser_count = 3'd1;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_fire) begin
                    if (!op_known(cmd_byte)) begin
                        state_nxt = ST_RSP;
                        ser_load  = 1'b1;
                        ser_word  = {24'h0, RSP_UNKNOWN};
                    end else if (op_has_addr(cmd_byte)) begin
                        state_nxt = ST_ADDR;
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_ADDR: begin
                cmd_ready = 1'b1;
                if (cmd_fire) begin
                    state_nxt = op_is_read(op_q) ? ST_EXEC : ST_DATA;
                end
            end
            ST_DATA: begin
                cmd_ready = 1'b1;
                if (cmd_fire && (cnt_q == 2'd3)) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_RSP;
                ser_load  = 1'b1;
                // Read data is captured here, at the end of the EXEC cycle.
                if (op_has_addr(op_q) && !halt_q) begin
                    ser_word = {24'h0, RSP_BUSY};
                end else if (op_q == OP_RD_DM) begin
                    ser_word  = dm_rdata;
                    ser_count = 3'd4;
                end else if (op_q == OP_RD_RF) begin
                    ser_word  = rf_rdata;
                    ser_count = 3'd4;
                end else begin
                    ser_word = {24'h0, RSP_ACK};
                end
            end
            ST_RSP: begin
                if (ser_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 8'h00;
            addr_q <= '0;
            data_q <= 32'h0;
            cnt_q  <= 2'd0;
            halt_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (cmd_fire) begin
                    op_q  <= cmd_byte;
                    cnt_q <= 2'd0;
                end
                ST_ADDR: if (cmd_fire) addr_q <= cmd_byte[AW-1:0];
                ST_DATA: if (cmd_fire) begin
                    data_q <= {cmd_byte, data_q[31:8]};
                    cnt_q  <= cnt_q + 2'd1;
                end
                ST_EXEC: begin
                    if (op_q == OP_RUN) halt_q <= 1'b0;
                    if (op_q == OP_HALT) halt_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Every strobe, including STEP, only fires while the core is halted.
    assign exec_ok  = (state == ST_EXEC) && halt_q;
    assign im_we    = exec_ok && (op_q == OP_WR_IM);
    assign dm_we    = exec_ok && (op_q == OP_WR_DM);
    assign rf_we    = exec_ok && (op_q == OP_WR_RF) && (addr_q[4:0] != 5'd0);
    assign pc_we    = exec_ok && (op_q == OP_SET_PC);
    assign cpu_step = exec_ok && (op_q == OP_STEP);
    assign cpu_halt = halt_q;

    assign im_addr  = addr_q[IM_AW-1:0];
    assign dm_addr  = addr_q[DM_AW-1:0];
    assign rf_addr  = addr_q[4:0];
    assign im_wdata = data_q;
    assign dm_wdata = data_q;
    assign rf_wdata = data_q;
    assign pc_wdata = data_q;

    dbg_rsp_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word      (ser_word),
        .count     (ser_count),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_byte  (rsp_byte),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_risc32_debug_bridge.sv
// Scoreboard bench: frame-level reference model feeds expected bytes/strobes to a decoupled monitor.
module tb_risc32_debug_bridge;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_byte;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_byte;
    logic        im_we;
    logic [3:0]  im_addr;
    logic [31:0] im_wdata;
    logic        dm_we;
    logic [4:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        pc_we;
    logic [31:0] pc_wdata;
    logic        cpu_halt;
    logic        cpu_step;

    risc32_debug_bridge #(.IM_AW(4), .DM_AW(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_byte(rsp_byte),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .pc_we(pc_we), .pc_wdata(pc_wdata),
        .cpu_halt(cpu_halt), .cpu_step(cpu_step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    localparam int EV_IM = 1, EV_DM = 2, EV_RF = 3, EV_PC = 4, EV_STEP = 5;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  rsp_q[$];
    ev_t         ev_q[$];
    int          hold_cnt = 0;
    logic        mem_init = 1'b0;

    // Stand-in for the datapath memories the bridge talks to.
    logic [31:0] dm_mem[32];
    logic [31:0] rf_mem[32];
    // Reference model state, updated from frame semantics alone.
    logic [31:0] ref_dm[32];
    logic [31:0] ref_rf[32];
    logic        ref_halted;

    function automatic logic [31:0] init_val(input int idx, input logic is_rf);
        if (is_rf && idx == 0) return 32'h0;
        return (32'h01010101 * idx) ^ (is_rf ? 32'h5A000000 : 32'h00C0DE00);
    endfunction

    assign dm_rdata = dm_mem[dm_addr];
    assign rf_rdata = rf_mem[rf_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) begin
                dm_mem[i] <= init_val(i, 1'b0);
                rf_mem[i] <= init_val(i, 1'b1);
            end
        end else begin
            if (dm_we) dm_mem[dm_addr] <= dm_wdata;
            if (rf_we) rf_mem[rf_addr] <= rf_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        checks++;
        if (ev_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe actual=kind%0d addr=%h data=%h required=none", kind, addr, data);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != kind || e.addr !== addr || e.data !== data) begin
                failures++;
                $display("FAIL strobe actual=kind%0d/%h/%h required=kind%0d/%h/%h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Host-side rsp_ready: mostly ready, with a forced stall window when hold_cnt is set.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_cnt > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) hold_cnt--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: compares every presented response byte and every strobe against the scoreboard.
    initial begin
        logic       hold_prev;
        logic [7:0] hold_byte;
        logic [7:0] exp_b;
        hold_prev = 1'b0;
        hold_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("rsp_hold_valid", {31'h0, rsp_valid}, 32'h1);
                    chk("rsp_hold_byte", {24'h0, rsp_byte}, {24'h0, hold_byte});
                end
                hold_prev = rsp_valid && !rsp_ready;
                hold_byte = rsp_byte;
                if (rsp_valid && rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_extra actual=%h required=none", rsp_byte);
                    end else begin
                        exp_b = rsp_q.pop_front();
                        chk("rsp_byte", {24'h0, rsp_byte}, {24'h0, exp_b});
                    end
                end
                if (im_we)    check_ev(EV_IM, {28'h0, im_addr}, im_wdata);
                if (dm_we)    check_ev(EV_DM, {27'h0, dm_addr}, dm_wdata);
                if (rf_we)    check_ev(EV_RF, {27'h0, rf_addr}, rf_wdata);
                if (pc_we)    check_ev(EV_PC, 32'h0, pc_wdata);
                if (cpu_step) check_ev(EV_STEP, 32'h0, 32'h0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("cmd_ready_timeout", 32'h0, 32'h1);
        cmd_valid = 1'b1;
        cmd_byte  = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) rsp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic push_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        ev_q.push_back(e);
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] data);
        logic known;
        logic has_addr;
        logic has_data;
        int   t;
        known    = (op >= 8'd1 && op <= 8'd9);
        has_addr = (op >= 8'd1 && op <= 8'd6);
        has_data = (op == 8'd1 || op == 8'd2 || op == 8'd3 || op == 8'd6);

        if (!known) begin
            rsp_q.push_back(8'hEE);
        end else if (has_addr && !ref_halted) begin
            rsp_q.push_back(8'hE1);
        end else begin
            case (op)
                8'd1: begin push_ev(EV_IM, {28'h0, addr[3:0]}, data); rsp_q.push_back(8'hA5); end
                8'd2: begin
                    push_ev(EV_DM, {27'h0, addr[4:0]}, data);
                    ref_dm[addr[4:0]] = data;
                    rsp_q.push_back(8'hA5);
                end
                8'd3: begin
                    if (addr[4:0] != 5'd0) begin
                        push_ev(EV_RF, {27'h0, addr[4:0]}, data);
                        ref_rf[addr[4:0]] = data;
                    end
                    rsp_q.push_back(8'hA5);
                end
                8'd4: push_word(ref_dm[addr[4:0]]);
                8'd5: push_word(ref_rf[addr[4:0]]);
                8'd6: begin push_ev(EV_PC, 32'h0, data); rsp_q.push_back(8'hA5); end
                8'd7: begin
                    if (ref_halted) push_ev(EV_STEP, 32'h0, 32'h0);
                    rsp_q.push_back(8'hA5);
                end
                8'd8: begin ref_halted = 1'b0; rsp_q.push_back(8'hA5); end
                default: begin ref_halted = 1'b1; rsp_q.push_back(8'hA5); end
            endcase
        end

        send_byte(op);
        if (has_addr) send_byte(addr);
        if (has_data) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);

        // Response latency: N+1 for an unknown opcode, otherwise EXEC at N+1 and valid from N+2.
        @(negedge clk);
        if (!known) begin
            chk("rsp_latency_unknown", {31'h0, rsp_valid}, 32'h1);
        end else begin
            chk("rsp_quiet_in_exec", {31'h0, rsp_valid}, 32'h0);
            @(negedge clk);
            chk("rsp_latency", {31'h0, rsp_valid}, 32'h1);
        end

        t = 0;
        while (!(rsp_q.size() == 0 && cmd_ready && !rsp_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("frame_drain_timeout", 32'h0, 32'h1);
        chk("missing_strobes", ev_q.size(), 32'h0);
        chk("cpu_halt", {31'h0, cpu_halt}, {31'h0, ref_halted});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_halted = 1'b1;
        rsp_q.delete();
        ev_q.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  op;
        logic [7:0]  tmp;
        int          r;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        mem_init  = 1'b1;
        ref_halted = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ref_dm[i] = init_val(i, 1'b0);
            ref_rf[i] = init_val(i, 1'b1);
        end
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        chk("reset_cpu_halt", {31'h0, cpu_halt}, 32'h1);
        chk("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_strobes", {27'h0, im_we, dm_we, rf_we, pc_we, cpu_step}, 32'h0);
        chk("reset_addr", {18'h0, im_addr, dm_addr, rf_addr}, 32'h0);
        chk("reset_data", im_wdata | dm_wdata | rf_wdata | pc_wdata, 32'h0);

        run_frame(8'h01, 8'h00, 32'h00100013);
        run_frame(8'h02, 8'h21, 32'h00007F7F);
        run_frame(8'h04, 8'h01, 32'h0);
        run_frame(8'h02, 8'h1F, 32'hCAFEF00D);
        run_frame(8'h04, 8'h3F, 32'h0);
        run_frame(8'h03, 8'h00, 32'hDEADBEEF);
        run_frame(8'h05, 8'h00, 32'h0);
        run_frame(8'h03, 8'h03, 32'h00001000);
        run_frame(8'h05, 8'h03, 32'h0);
        run_frame(8'h06, 8'hFF, 32'h00000040);
        run_frame(8'h08, 8'h00, 32'h0);
        run_frame(8'h02, 8'h05, 32'h12345678);
        run_frame(8'h04, 8'h05, 32'h0);
        run_frame(8'h07, 8'h00, 32'h0);
        run_frame(8'h09, 8'h00, 32'h0);
        run_frame(8'h07, 8'h00, 32'h0);
        run_frame(8'h55, 8'h00, 32'h0);
        run_frame(8'h09, 8'h00, 32'h0);
        run_frame(8'h04, 8'h05, 32'h0);

        hold_cnt = 5;
        run_frame(8'h04, 8'h01, 32'h0);
        hold_cnt = 0;

        // Reset while running must bring the core back to halted.
        run_frame(8'h08, 8'h00, 32'h0);
        do_reset();
        chk("rst_run_cpu_halt", {31'h0, cpu_halt}, 32'h1);

        // Reset after the 3rd data byte of WR_IM: the frame is dropped without a strobe.
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h10);
        do_reset();
        chk("rst_mid_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_mid_cpu_halt", {31'h0, cpu_halt}, 32'h1);
        chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        run_frame(8'h01, 8'h07, 32'h00A00093);

        for (int n = 0; n < 160; n++) begin
            r = $urandom_range(0, 19);
            if (r < 2) begin
                tmp = 8'($urandom_range(10, 255));
                op  = (r == 0) ? 8'h00 : tmp;
            end else begin
                op = 8'(1 + (r % 9));
            end
            run_frame(op, 8'($urandom_range(0, 255)), $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/risc32_debug_bridge.md
# risc32_debug_bridge

Byte-stream debug bridge for the Risc32 single-cycle core: an external host (bench, UART wrapper) sends command frames that halt, single-step or run the core and read or write instruction memory, data memory, register file and PC through dedicated side ports. Hardware counterpart of the hierarchical poke/peek bench flow, so programs can be loaded and checked without hierarchy access. Sits between the host link and the `datapath` memory/register-file debug ports.

## Interface
- `IM_AW`, 4: instruction-memory word-address width.
- `DM_AW`, 5: data-memory word-address width (32 words).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1 / `cmd_byte` in 8: host command stream.
- `rsp_valid` out 1 / `rsp_ready` in 1 / `rsp_byte` out 8: response stream to host.
- `im_we` out 1, `im_addr` out IM_AW, `im_wdata` out 32: instruction-memory write port.
- `dm_we` out 1, `dm_addr` out DM_AW, `dm_wdata` out 32, `dm_rdata` in 32: data-memory port, combinational read.
- `rf_we` out 1, `rf_addr` out 5, `rf_wdata` out 32, `rf_rdata` in 32: register-file port, combinational read.
- `pc_we` out 1, `pc_wdata` out 32: PC load.
- `cpu_halt` out 1: core clock-enable gated off while high.
- `cpu_step` out 1: one-cycle enable pulse while halted; the core executes exactly one instruction.

## Operation
- Frame: opcode byte, then address byte (only for opcodes 0x01–0x06), then 4 data bytes little-endian (only for 0x01, 0x02, 0x03, 0x06; the address byte is present but ignored for 0x06).
- Opcodes:
  - 0x01 WR_IM.
  - 0x02 WR_DM.
  - 0x03 WR_RF.
  - 0x04 RD_DM.
  - 0x05 RD_RF.
  - 0x06 SET_PC.
  - 0x07 STEP.
  - 0x08 RUN (clear `cpu_halt`).
  - 0x09 HALT (set `cpu_halt`).
- Responses:
  - Writes and controls return 0xA5.
  - Reads return 4 bytes, LSB first.
  - An unknown opcode returns 0xEE and consumes only the opcode byte.
- Address masking: the address byte is masked to IM_AW, DM_AW or 5 bits (wrap): DM address 0x20 maps to word 0, and 0x1F maps to word 31.
- WR_RF to x0: frame consumed and acked 0xA5, `rf_we` suppressed.
- Memory, RF or PC access (0x01–0x06) while `cpu_halt`=0: full frame consumed, no strobe, single response byte 0xE1 (busy).
- STEP while running: ack 0xA5, no `cpu_step` pulse.
- Controls 0x07–0x09 have no address byte.
- States:
  - IDLE: takes the opcode; on a valid opcode goes to ADDR, or to EXEC for 0x07–0x09; on an unknown opcode goes to RSP.
  - ADDR: takes the address; reads go to EXEC, writes go to DATA.
  - DATA: 2-bit counter 0..3; after the 4th byte goes to EXEC.
  - EXEC: one cycle, then RSP.
  - RSP: byte counter; after the last accepted byte goes to IDLE.

## Timing
- A byte is accepted on a rising edge with valid&ready.
- `cmd_ready`=1 only in IDLE, ADDR and DATA.
- Last command byte accepted at edge N:
  - EXEC during cycle N+1. `*_we`, `pc_we` and `cpu_step` are high for exactly that cycle.
  - Read data is sampled from `dm_rdata`/`rf_rdata` at the end of EXEC.
  - `rsp_valid` is high from cycle N+2.
- `rsp_byte` is stable while `rsp_valid`=1 and `rsp_ready`=0. The next byte is presented the cycle after a handshake; `rsp_valid` may stay high across bytes.
- `cpu_halt` changes at the end of EXEC for RUN/HALT.
- Reset values:
  - `cpu_halt`=1.
  - `cmd_ready`=1 (IDLE).
  - All strobes, `rsp_valid`, address and data outputs are 0.
- Reset mid-frame or mid-response: frame abandoned, no strobe issued, pending response dropped.

## Structure
- Package `risc32_dbg_pkg`:
  - opcode constants (0x01–0x09);
  - response codes (0xA5, 0xEE, 0xE1);
  - state enum (IDLE, ADDR, DATA, EXEC, RSP).
- Sub-module `dbg_rsp_serializer`: loads a 32-bit word plus a byte count (1 or 4) and shifts bytes out under the valid/ready handshake.

## Test plan
- After reset: `cpu_halt`=1; send 01 00 13 00 10 00 → `im_we` pulse, `im_addr`=0, `im_wdata`=0x00100013, response A5.
- WR_DM addr 0x21 data 7F 7F 00 00 → `dm_addr`=1, `dm_wdata`=0x00007F7F; RD_DM 0x01 with `dm_rdata`=0x00007F7F → responses 7F 7F 00 00.
- WR_RF addr 0 → no `rf_we`, response A5. RD_RF 3 with `rf_rdata`=0x00001000 → 00 10 00 00.
- RUN → `cpu_halt`=0, A5. WR_DM during run → E1 with no strobe. STEP → A5 with no pulse. HALT → `cpu_halt`=1. STEP → exactly one `cpu_step` cycle, A5.
- Opcode 0x55 → EE; the next byte is treated as an opcode. Hold `rsp_ready`=0 for 5 cycles during a read → `rsp_byte` held stable.
- Assert `rst` after the 3rd data byte of WR_IM → no `im_we`, `cmd_ready`=1 and `cpu_halt`=1 after reset, next frame decoded normally.
